// File: rtl/tpumac_pkg.sv
// Shared constants and signed-limit helpers for the TPU MAC cell family.
package tpumac_pkg;

  localparam int unsigned BitsAbDef = 8;
  localparam int unsigned BitsCDef  = 16;

  // Largest two's-complement value representable in w bits (1 <= w <= 64).
  function automatic logic signed [63:0] sat_max(input int unsigned w);
    return (64'sd1 <<< (w - 1)) - 64'sd1;
  endfunction

  // Most negative two's-complement value representable in w bits.
  function automatic logic signed [63:0] sat_min(input int unsigned w);
    return -(64'sd1 <<< (w - 1));
  endfunction

endpackage

// File: rtl/tpumac_satadd.sv
// Combinational accumulate: exact sum of accumulator and product, overflow detect,
// and optional clamp to the accumulator range.
module tpumac_satadd
  import tpumac_pkg::*;
#(
  parameter int unsigned BITS_C = BitsCDef,
  parameter int unsigned BITS_P = 2 * BitsAbDef,
  parameter bit          SAT_EN = 1'b1
) (
  input  logic [BITS_C-1:0] acc,
  input  logic [BITS_P-1:0] prod,
  output logic [BITS_C-1:0] sum,
  output logic              ovf
);

  localparam logic [BITS_C-1:0] MaxVal = BITS_C'(sat_max(BITS_C));
  localparam logic [BITS_C-1:0] MinVal = BITS_C'(sat_min(BITS_C));

  logic [BITS_C:0] acc_x;
  logic [BITS_C:0] prod_x;
  logic [BITS_C:0] sum_x;

  assign acc_x  = {acc[BITS_C-1], acc};
  assign prod_x = {{(BITS_C + 1 - BITS_P){prod[BITS_P-1]}}, prod};
  assign sum_x  = acc_x + prod_x;

  // One extra bit holds the exact sum; a mismatch of the top two bits means out of range.
  assign ovf = sum_x[BITS_C] ^ sum_x[BITS_C-1];

  always_comb begin
    sum = sum_x[BITS_C-1:0];
    if (SAT_EN && ovf) begin
      sum = sum_x[BITS_C] ? MinVal : MaxVal;
    end
  end

endmodule

// File: rtl/tpumac_sat.sv
// Systolic MAC cell: operand passthrough, optional product pipeline stage,
// saturating or wrapping accumulator with sticky overflow.
module tpumac_sat
  import tpumac_pkg::*;
#(
  parameter int unsigned BITS_AB = BitsAbDef,
  parameter int unsigned BITS_C  = BitsCDef,
  parameter bit          SAT_EN  = 1'b1,
  parameter bit          PIPE    = 1'b0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               WrEn,
  input  logic               vin,
  input  logic [BITS_AB-1:0] Ain,
  input  logic [BITS_AB-1:0] Bin,
  input  logic [BITS_C-1:0]  Cin,
  output logic [BITS_AB-1:0] Aout,
  output logic [BITS_AB-1:0] Bout,
  output logic               vout,
  output logic [BITS_C-1:0]  Cout,
  output logic               ovf
);

  localparam int unsigned BitsP = 2 * BITS_AB;

  logic [BitsP-1:0]  a_x;
  logic [BitsP-1:0]  b_x;
  logic [BitsP-1:0]  prod_c;
  logic [BitsP-1:0]  acc_prod;
  logic              acc_go;
  logic [BITS_C-1:0] sum;
  logic              sum_ovf;

  // Sign-extending both operands to the product width keeps the low half exact.
  assign a_x    = {{BITS_AB{Ain[BITS_AB-1]}}, Ain};
  assign b_x    = {{BITS_AB{Bin[BITS_AB-1]}}, Bin};
  assign prod_c = a_x * b_x;

  if (PIPE) begin : g_pipe
    logic [BitsP-1:0] prod_q;
    logic             prod_v;

    always_ff @(posedge clk) begin
      if (rst) begin
        prod_q <= '0;
        prod_v <= 1'b0;
      end else if (en) begin
        prod_q <= prod_c;
        prod_v <= vin & ~WrEn;
      end
    end

    assign acc_prod = prod_q;
    assign acc_go   = prod_v;
  end else begin : g_nopipe
    assign acc_prod = prod_c;
    assign acc_go   = vin;
  end

  tpumac_satadd #(
    .BITS_C (BITS_C),
    .BITS_P (BitsP),
    .SAT_EN (SAT_EN)
  ) u_satadd (
    .acc  (Cout),
    .prod (acc_prod),
    .sum  (sum),
    .ovf  (sum_ovf)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      Aout <= '0;
      Bout <= '0;
      vout <= 1'b0;
      Cout <= '0;
      ovf  <= 1'b0;
    end else if (en) begin
      Aout <= Ain;
      Bout <= Bin;
      vout <= vin;
      if (WrEn) begin
        Cout <= Cin;
        ovf  <= 1'b0;
      end else if (acc_go) begin
        Cout <= sum;
        if (sum_ovf) begin
          ovf <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_tpumac_sat.sv
// Directed bench: three cell configurations (saturating, wrapping, pipelined)
// driven from shared inputs, each scenario checked against hand-computed values.
module tb_tpumac_sat;

  logic        clk = 1'b0;
  logic        rst, en, WrEn, vin;
  logic [7:0]  Ain, Bin;
  logic [15:0] Cin;

  logic signed [7:0]  a0, b0, a1, b1, a2, b2;
  logic signed [15:0] c0, c1, c2;
  logic               v0, v1, v2, o0, o1, o2;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  tpumac_sat #(.BITS_AB(8), .BITS_C(16), .SAT_EN(1'b1), .PIPE(1'b0)) dut_sat (
    .clk(clk), .rst(rst), .en(en), .WrEn(WrEn), .vin(vin), .Ain(Ain), .Bin(Bin),
    .Cin(Cin), .Aout(a0), .Bout(b0), .vout(v0), .Cout(c0), .ovf(o0)
  );

  tpumac_sat #(.BITS_AB(8), .BITS_C(16), .SAT_EN(1'b0), .PIPE(1'b0)) dut_wrap (
    .clk(clk), .rst(rst), .en(en), .WrEn(WrEn), .vin(vin), .Ain(Ain), .Bin(Bin),
    .Cin(Cin), .Aout(a1), .Bout(b1), .vout(v1), .Cout(c1), .ovf(o1)
  );

  tpumac_sat #(.BITS_AB(8), .BITS_C(16), .SAT_EN(1'b1), .PIPE(1'b1)) dut_pipe (
    .clk(clk), .rst(rst), .en(en), .WrEn(WrEn), .vin(vin), .Ain(Ain), .Bin(Bin),
    .Cin(Cin), .Aout(a2), .Bout(b2), .vout(v2), .Cout(c2), .ovf(o2)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [15:0] val);
    WrEn = 1'b1; vin = 1'b0; Cin = val;
    step();
    WrEn = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b1; WrEn = 1'b1; vin = 1'b1; Ain = 8'd5; Bin = 8'd6; Cin = 16'd9;
    step();
    rst = 1'b0; WrEn = 1'b0; vin = 1'b0;
    checks++;
    if ({a0, b0, v0, c0, o0} !== '0) begin
      failures++; $display("FAIL reset_sat: got A=%0d B=%0d v=%0b C=%0d ovf=%0b required all 0",
                           a0, b0, v0, c0, o0);
    end
    checks++;
    if ({a2, b2, v2, c2, o2} !== '0) begin
      failures++; $display("FAIL reset_pipe: got A=%0d B=%0d v=%0b C=%0d ovf=%0b required all 0",
                           a2, b2, v2, c2, o2);
    end
  endtask

  task automatic test_sat_pos();
    load(16'd32000);
    vin = 1'b1; Ain = 8'd100; Bin = 8'd10;
    step();
    checks++;
    if (c0 !== 16'sd32767 || o0 !== 1'b1) begin
      failures++; $display("FAIL sat_pos_clamp: got C=%0d ovf=%0b required C=32767 ovf=1", c0, o0);
    end
    Ain = 8'hFF; Bin = 8'd1;
    step();
    vin = 1'b0;
    checks++;
    if (c0 !== 16'sd32766 || o0 !== 1'b1) begin
      failures++; $display("FAIL sat_pos_sticky: got C=%0d ovf=%0b required C=32766 ovf=1", c0, o0);
    end
  endtask

  task automatic test_sat_neg();
    load(16'h8000);
    vin = 1'b1; Ain = 8'hFF; Bin = 8'd1;
    step();
    vin = 1'b0;
    checks++;
    if (c0 !== -16'sd32768 || o0 !== 1'b1) begin
      failures++; $display("FAIL sat_neg_clamp: got C=%0d ovf=%0b required C=-32768 ovf=1", c0, o0);
    end
    load(16'd5);
    checks++;
    if (c0 !== 16'sd5 || o0 !== 1'b0) begin
      failures++; $display("FAIL wren_clears_ovf: got C=%0d ovf=%0b required C=5 ovf=0", c0, o0);
    end
  endtask

  task automatic test_wrap();
    load(16'd32767);
    vin = 1'b1; Ain = 8'd1; Bin = 8'd1;
    step();
    vin = 1'b0;
    checks++;
    if (c1 !== -16'sd32768 || o1 !== 1'b1) begin
      failures++; $display("FAIL wrap: got C=%0d ovf=%0b required C=-32768 ovf=1", c1, o1);
    end
    checks++;
    if (c0 !== 16'sd32767 || o0 !== 1'b1) begin
      failures++; $display("FAIL sat_at_max: got C=%0d ovf=%0b required C=32767 ovf=1", c0, o0);
    end
  endtask

  task automatic test_pipe();
    load(16'd0);
    vin = 1'b1; Ain = 8'd3; Bin = 8'd4;
    step();
    vin = 1'b0;
    checks++;
    if (c2 !== 16'sd0) begin
      failures++; $display("FAIL pipe_edge1: got C=%0d required 0", c2);
    end
    step();
    checks++;
    if (c2 !== 16'sd12) begin
      failures++; $display("FAIL pipe_edge2: got C=%0d required 12", c2);
    end
    load(16'd0);
    vin = 1'b1; Ain = 8'd3; Bin = 8'd4;
    step();
    vin = 1'b0; WrEn = 1'b1; Cin = 16'd7;
    step();
    WrEn = 1'b0;
    step();
    step();
    checks++;
    if (c2 !== 16'sd7 || o2 !== 1'b0) begin
      failures++; $display("FAIL pipe_discard: got C=%0d ovf=%0b required C=7 ovf=0", c2, o2);
    end
  endtask

  task automatic test_corner();
    logic signed [15:0] exp_c [3];
    logic               exp_o [3];
    exp_c[0] = 16'sd16384; exp_o[0] = 1'b0;
    exp_c[1] = 16'sd32767; exp_o[1] = 1'b1;
    exp_c[2] = 16'sd32767; exp_o[2] = 1'b1;
    load(16'd0);
    vin = 1'b1; Ain = 8'h80; Bin = 8'h80;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (c0 !== exp_c[i] || o0 !== exp_o[i] || a0 !== -8'sd128 || b0 !== -8'sd128) begin
        failures++; $display("FAIL corner_%0d: got C=%0d ovf=%0b A=%0d B=%0d required C=%0d ovf=%0b A=B=-128",
                             i, c0, o0, a0, b0, exp_c[i], exp_o[i]);
      end
    end
    vin = 1'b0;
    for (int i = 0; i < 4; i++) begin
      Ain = 8'(i * 37 + 1); Bin = 8'(8'hF0 - i * 19); vin = i[0];
      step();
      checks++;
      if (a0 !== 8'(i * 37 + 1) || b0 !== 8'(8'hF0 - i * 19) || v0 !== i[0]) begin
        failures++; $display("FAIL passthru_%0d: got A=%0h B=%0h v=%0b required A=%0h B=%0h v=%0b",
                             i, a0, b0, v0, 8'(i * 37 + 1), 8'(8'hF0 - i * 19), i[0]);
      end
    end
    vin = 1'b0;
  endtask

  task automatic test_hold_reset();
    load(16'd100);
    vin = 1'b1; Ain = 8'd2; Bin = 8'd3;
    step();
    en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      Ain = 8'(5 + i); Bin = 8'(7 + i); WrEn = i[0]; Cin = 16'd999;
      step();
      checks++;
      if (c0 !== 16'sd106 || a0 !== 8'sd2 || b0 !== 8'sd3 || v0 !== 1'b1 || o0 !== 1'b0 ||
          c2 !== 16'sd100) begin
        failures++; $display("FAIL hold_%0d: got C=%0d A=%0d B=%0d v=%0b ovf=%0b Cp=%0d required 106 2 3 1 0 100",
                             i, c0, a0, b0, v0, o0, c2);
      end
    end
    en = 1'b1; WrEn = 1'b0; vin = 1'b0;
    step();
    checks++;
    if (c2 !== 16'sd106) begin
      failures++; $display("FAIL pipe_held_prod: got C=%0d required 106", c2);
    end
    vin = 1'b1; Ain = 8'd9; Bin = 8'd9;
    step();
    rst = 1'b1;
    step();
    rst = 1'b0; vin = 1'b0;
    checks++;
    if ({a0, b0, v0, c0, o0} !== '0 || {a2, b2, v2, c2, o2} !== '0) begin
      failures++; $display("FAIL midstream_reset: got C=%0d A=%0d Cp=%0d Ap=%0d required all 0",
                           c0, a0, c2, a2);
    end
    step();
    checks++;
    if (c2 !== 16'sd0) begin
      failures++; $display("FAIL reset_discard: got C=%0d required 0", c2);
    end
    vin = 1'b1; Ain = 8'd1; Bin = 8'd2;
    step();
    vin = 1'b0;
    step();
    checks++;
    if (c0 !== 16'sd2 || c2 !== 16'sd2) begin
      failures++; $display("FAIL post_reset_acc: got C=%0d Cp=%0d required 2 2", c0, c2);
    end
  endtask

  initial begin
    rst = 1'b1; en = 1'b1; WrEn = 1'b0; vin = 1'b0; Ain = '0; Bin = '0; Cin = '0;
    test_reset();
    test_sat_pos();
    test_sat_neg();
    test_wrap();
    test_pipe();
    test_corner();
    test_hold_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
